uart_tx_scheduler: RTL

Round-robin scheduler that shares one UART transmitter and its baud-rate generator among N_REQ requesters.
- Each requester presents a data byte and a 2-bit baud selection.
- The scheduler grants one requester at a time and drives the generator's bd_rate select.
- When the rate changes, it holds for a settle window so the TX bit clock is stable, then pulses tx_start and waits for tx_done before serving the next requester.

---
 rtl/uart_tx_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter and baud generator.
// Define TX_TIMEOUT_EN to add the WAIT_DONE watchdog and tx_timeout port.
module uart_tx_scheduler #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ*2-1:0]         req_baud,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   active_id,
    output logic [1:0]                 bd_rate,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    input  logic                       tx_done,
`ifdef TX_TIMEOUT_EN
    output logic                       sched_busy,
    output logic                       tx_timeout
`else
    output logic                       sched_busy
`endif
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int SC_W = $clog2(SETTLE_CYC + 1);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("N_REQ must be 2..8");
    end
    if (SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cyc
        $error("SETTLE_CYC and TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, START, WAIT_DONE} state_t;

    state_t              state, state_nx;
    logic [ID_W-1:0]     rr_ptr, rr_nx, id_nx, win, idx, ptr_after;
    logic                found;
    logic [SC_W-1:0]     cnt, cnt_nx;
    logic [N_REQ-1:0]    grant_nx;
    logic [1:0]          bd_nx;
    logic [DATA_W-1:0]   data_nx;
    logic                start_nx;
    logic [DATA_W-1:0]   data_arr [N_REQ];
    logic [1:0]          baud_arr [N_REQ];

`ifdef TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd, wd_nx;
    logic            to_nx;
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
        assign baud_arr[g] = req_baud[g*2 +: 2];
    end

    // First requesting index at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        win   = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign ptr_after = (active_id == ID_W'(N_REQ - 1)) ? '0
                                                       : active_id + 1'b1;

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        id_nx    = active_id;
        bd_nx    = bd_rate;
        data_nx  = tx_data;
        cnt_nx   = cnt;
        grant_nx = '0;
        start_nx = 1'b0;
`ifdef TX_TIMEOUT_EN
        wd_nx    = wd;
        to_nx    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_nx[win] = 1'b1;
                    id_nx         = win;
                    data_nx       = data_arr[win];
                    if (baud_arr[win] != bd_rate) begin
                        bd_nx    = baud_arr[win];
                        cnt_nx   = SC_W'(SETTLE_CYC);
                        state_nx = SETTLE;
                    end else begin
                        state_nx = START;
                    end
                end
            end
            SETTLE: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == SC_W'(1)) state_nx = START;
            end
            START: begin
                if (!tx_busy) begin
                    start_nx = 1'b1;
                    state_nx = WAIT_DONE;
`ifdef TX_TIMEOUT_EN
                    wd_nx    = '0;
`endif
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    rr_nx    = ptr_after;
                    state_nx = IDLE;
                end
`ifdef TX_TIMEOUT_EN
                else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                    to_nx    = 1'b1;
                    rr_nx    = ptr_after;
                    state_nx = IDLE;
                end else begin
                    wd_nx = wd + 1'b1;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            grant      <= '0;
            active_id  <= '0;
            bd_rate    <= 2'b00;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            sched_busy <= 1'b0;
`ifdef TX_TIMEOUT_EN
            wd         <= '0;
            tx_timeout <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            rr_ptr     <= rr_nx;
            cnt        <= cnt_nx;
            grant      <= grant_nx;
            active_id  <= id_nx;
            bd_rate    <= bd_nx;
            tx_data    <= data_nx;
            tx_start   <= start_nx;
            sched_busy <= (state_nx != IDLE);
`ifdef TX_TIMEOUT_EN
            wd         <= wd_nx;
            tx_timeout <= to_nx;
`endif
        end
    end

endmodule
